vga_timing_gen: RTL

- Parametrised VGA timing and pixel-output stage for the ice40 VGA device, the successor to the fixed 800x600 generator.
- Divides the fast PLL clock into a pixel enable and produces h/v request coordinates for an upstream pixel source.
- Delays sync and blanking through a PIPE_DELAY-stage line so they align with the returned pixel data.
- Sync polarity, all timings and colour width are parameters.

---
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-enable divider, request coordinates and a sync/blank delay line aligned to returned pixel data.
// Define TEST_PATTERN_EN to replace pix_r/g/b with a colour pattern derived from the delayed coordinate.
module vga_timing_gen #(
    parameter int CLK_DIV    = 6,
    parameter int H_VISIBLE  = 800,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BACK     = 88,
    parameter int V_VISIBLE  = 600,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BACK     = 23,
    parameter int HSYNC_POL  = 1,
    parameter int VSYNC_POL  = 1,
    parameter int CW         = 12,
    parameter int COLOR_BITS = 4,
    parameter int PIPE_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    output logic                  pix_en,
    output logic [CW-1:0]         hcount,
    output logic [CW-1:0]         vcount,
    output logic                  active,
    output logic                  line_start,
    output logic                  frame_start,
    input  logic [COLOR_BITS-1:0] pix_r,
    input  logic [COLOR_BITS-1:0] pix_g,
    input  logic [COLOR_BITS-1:0] pix_b,
    output logic                  hsync,
    output logic                  vsync,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int TW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PD       = (PIPE_DELAY > 0) ? PIPE_DELAY : 1;
    localparam logic HS_IDLE = (HSYNC_POL == 0);
    localparam logic VS_IDLE = (VSYNC_POL == 0);
`ifdef TEST_PATTERN_EN
    localparam int EW = 3 + 2 * CW;
`else
    localparam int EW = 3;
`endif

    logic [TW-1:0]         tick_q, tick_d;
    logic [CW-1:0]         hcount_q, hcount_d;
    logic [CW-1:0]         vcount_q, vcount_d;
    logic [PD-1:0][EW-1:0] pipe_q, pipe_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic [COLOR_BITS-1:0] red_q, red_d;
    logic [COLOR_BITS-1:0] green_q, green_d;
    logic [COLOR_BITS-1:0] blue_q, blue_d;

    logic                  active_w, hs_raw, vs_raw;
    logic [EW-1:0]         cur_entry, tap_entry;
    logic                  tap_active, tap_hs, tap_vs;
    logic [COLOR_BITS-1:0] src_r, src_g, src_b;

    assign pix_en   = (tick_q == '0) && nrst;
    assign active_w = (int'(hcount_q) < H_VISIBLE) && (int'(vcount_q) < V_VISIBLE);
    assign hs_raw   = (int'(hcount_q) >= HS_START) && (int'(hcount_q) < HS_END);
    assign vs_raw   = (int'(vcount_q) >= VS_START) && (int'(vcount_q) < VS_END);

`ifdef TEST_PATTERN_EN
    assign cur_entry = {hcount_q, vcount_q, active_w, hs_raw, vs_raw};
`else
    assign cur_entry = {active_w, hs_raw, vs_raw};
`endif

    // With no pipeline the pixel source is combinational, so the tap is the live coordinate.
    assign tap_entry  = (PIPE_DELAY == 0) ? cur_entry : pipe_q[PD-1];
    assign tap_active = tap_entry[2];
    assign tap_hs     = tap_entry[1];
    assign tap_vs     = tap_entry[0];

`ifdef TEST_PATTERN_EN
    logic [CW-1:0] tap_h, tap_v;
    logic          unused_pix;
    assign tap_h      = tap_entry[EW-1 -: CW];
    assign tap_v      = tap_entry[3 +: CW];
    assign src_r      = tap_h[8 -: COLOR_BITS] & {COLOR_BITS{tap_v[8]}};
    assign src_g      = tap_h[8 -: COLOR_BITS] & {COLOR_BITS{tap_v[7]}};
    assign src_b      = tap_h[8 -: COLOR_BITS] & {COLOR_BITS{tap_v[6]}};
    assign unused_pix = ^{pix_r, pix_g, pix_b};
`else
    assign src_r = pix_r;
    assign src_g = pix_g;
    assign src_b = pix_b;
`endif

    always_comb begin
        tick_d   = (tick_q == TW'(CLK_DIV - 1)) ? '0 : tick_q + TW'(1);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (hcount_q == CW'(H_TOTAL - 1)) begin
                hcount_d = '0;
                vcount_d = (vcount_q == CW'(V_TOTAL - 1)) ? '0 : vcount_q + CW'(1);
            end else begin
                hcount_d = hcount_q + CW'(1);
            end
        end
    end

    always_comb begin
        pipe_d  = pipe_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        if (pix_en) begin
            pipe_d[0] = cur_entry;
            for (int i = 1; i < PD; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
            hsync_d = tap_hs ^ HS_IDLE;
            vsync_d = tap_vs ^ VS_IDLE;
            red_d   = tap_active ? src_r : '0;
            green_d = tap_active ? src_g : '0;
            blue_d  = tap_active ? src_b : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            tick_q   <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            pipe_q   <= '0;
            hsync_q  <= HS_IDLE;
            vsync_q  <= VS_IDLE;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
        end else begin
            tick_q   <= tick_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            pipe_q   <= pipe_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign active      = active_w;
    assign line_start  = pix_en && (hcount_q == '0);
    assign frame_start = line_start && (vcount_q == '0);
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
endmodule
